// File: rtl/csr_unit.sv
// Machine-mode CSR unit: Zicsr read-modify-write, 64-bit cycle/instret counters,
// trap entry and mret updates to mstatus/mepc/mcause/mtval.
module csr_unit #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     MTVEC_RESET  = 32'h0000_0000,
    parameter logic [XLEN-1:0]     HART_ID      = '0,
    parameter bit                  HAS_COUNTERS = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic            csr_imm,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [11:0]     addr,
    output logic [XLEN-1:0] data_r,
    output logic            illegal,
    input  logic            instret_inc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_en,
    output logic [XLEN-1:0] epc_o,
    output logic [XLEN-1:0] tvec_o,
    output logic            mie_o
);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0]   MISA_VAL = 32'h4000_0100;
    localparam logic [XLEN-1:0]   MIE_MASK = 32'h0000_0888;
    localparam logic [2*XLEN-1:0] CNT_ONE  = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic              mie_q, mie_d;
    logic              mpie_q, mpie_d;
    logic [XLEN-1:0]   mie_reg_q, mie_reg_d;
    logic [XLEN-1:0]   mtvec_q, mtvec_d;
    logic [XLEN-1:0]   mscratch_q, mscratch_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [XLEN-1:0]   mtval_q, mtval_d;
    logic [2*XLEN-1:0] mcycle_q, mcycle_d;
    logic [2*XLEN-1:0] minstret_q, minstret_d;

    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] mstatus_rd;
    logic            implemented;
    logic            write_intent;
    logic            wr_en;

    assign mstatus_rd = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};

    always_comb begin
        implemented = 1'b1;
        rd_val      = '0;
        case (addr)
            A_MSTATUS:  rd_val = mstatus_rd;
            A_MISA:     rd_val = MISA_VAL;
            A_MIE:      rd_val = mie_reg_q;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MTVAL:    rd_val = mtval_q;
            A_MIP:      rd_val = '0;
            A_MHARTID:  rd_val = HART_ID;
            A_MCYCLE, A_CYCLE:       rd_val = mcycle_q[XLEN-1:0];
            A_MCYCLEH, A_CYCLEH:     rd_val = mcycle_q[2*XLEN-1:XLEN];
            A_MINSTRET, A_INSTRET:   rd_val = minstret_q[XLEN-1:0];
            A_MINSTRETH, A_INSTRETH: rd_val = minstret_q[2*XLEN-1:XLEN];
            default:    implemented = 1'b0;
        endcase
        if (!HAS_COUNTERS && (addr[11:10] == 2'b10 || addr == A_CYCLE || addr == A_CYCLEH
                              || addr == A_INSTRET || addr == A_INSTRETH)) begin
            implemented = 1'b0;
            rd_val      = '0;
        end
    end

    assign operand      = csr_imm ? {{(XLEN-5){1'b0}}, rs1} : rs1_data;
    assign write_intent = (csr_op == OP_RW) || ((csr_op != OP_NOP) && (rs1 != 5'd0));
    assign data_r       = rd_val;
    assign illegal      = csr_en && (csr_op != OP_NOP)
                          && (!implemented || (addr[11:10] == 2'b11 && write_intent));
    assign wr_en        = csr_en && write_intent && !illegal && !trap_en;

    always_comb begin
        case (csr_op)
            OP_RW:   wdata = operand;
            OP_RS:   wdata = rd_val | operand;
            default: wdata = rd_val & ~operand;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mie_reg_d  = mie_reg_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + CNT_ONE;
        minstret_d = instret_inc ? minstret_q + CNT_ONE : minstret_q;

        // A write to either counter half replaces that cycle's increment.
        if (wr_en) begin
            case (addr)
                A_MSTATUS: begin
                    mie_d  = wdata[3];
                    mpie_d = wdata[7];
                end
                A_MIE:       mie_reg_d  = wdata & MIE_MASK;
                A_MTVEC:     mtvec_d    = {wdata[XLEN-1:2], 2'b00};
                A_MSCRATCH:  mscratch_d = wdata;
                A_MEPC:      mepc_d     = {wdata[XLEN-1:2], 2'b00};
                A_MCAUSE:    mcause_d   = wdata;
                A_MTVAL:     mtval_d    = wdata;
                A_MCYCLE:    mcycle_d   = {mcycle_q[2*XLEN-1:XLEN], wdata};
                A_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[XLEN-1:0]};
                A_MINSTRET:  minstret_d = {minstret_q[2*XLEN-1:XLEN], wdata};
                A_MINSTRETH: minstret_d = {wdata, minstret_q[XLEN-1:0]};
                default: ;
            endcase
        end

        if (mret_en) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (trap_en) begin
            mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end

        if (!HAS_COUNTERS) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mie_reg_q  <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mie_reg_q  <= mie_reg_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign epc_o  = mepc_q;
    assign tvec_o = mtvec_q;
    assign mie_o  = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expectations are queued as stimulus is driven
// and popped against DUT outputs one settle delay later.
module tb_csr_unit;

    localparam logic [31:0] TVEC_RST = 32'h0000_0100;
    localparam logic [31:0] HART     = 32'd5;
    localparam logic [1:0]  NOP = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic [4:0]  rs1;
    logic [31:0] rs1_data;
    logic [11:0] addr;
    logic [31:0] data_r;
    logic        illegal;
    logic        instret_inc;
    logic        trap_en;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret_en;
    logic [31:0] epc_o;
    logic [31:0] tvec_o;
    logic        mie_o;

    csr_unit #(
        .XLEN(32),
        .MTVEC_RESET(TVEC_RST),
        .HART_ID(HART),
        .HAS_COUNTERS(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .csr_en(csr_en), .csr_op(csr_op),
        .csr_imm(csr_imm), .rs1(rs1), .rs1_data(rs1_data), .addr(addr),
        .data_r(data_r), .illegal(illegal), .instret_inc(instret_inc),
        .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_en(mret_en), .epc_o(epc_o),
        .tvec_o(tvec_o), .mie_o(mie_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        csr_en = 0; csr_op = NOP; csr_imm = 0; rs1 = 0; rs1_data = 0; addr = 0;
        instret_inc = 0; trap_en = 0; trap_pc = 0; trap_cause = 0; trap_tval = 0;
        mret_en = 0;
    endtask

    task automatic csr(input logic [1:0] op, input logic imm, input logic [4:0] r,
                       input logic [31:0] d, input logic [11:0] a);
        csr_en = 1; csr_op = op; csr_imm = imm; rs1 = r; rs1_data = d; addr = a;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] v);
        csr(RS, 1'b0, 5'd0, 32'hFFFF_FFFF, a);
        expect_v(tag, v);
        #1;
        chk(data_r);
        tick();
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;

        expect_v("rst_epc", 32'h0);
        expect_v("rst_tvec", TVEC_RST);
        expect_v("rst_mie", 32'h0);
        #1;
        chk(epc_o); chk(tvec_o); chk({31'b0, mie_o});
        read_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        read_chk("misa", 12'h301, 32'h4000_0100);
        read_chk("mhartid", 12'hF14, HART);

        csr(RW, 1'b0, 5'd1, 32'hDEAD_BEEF, 12'h340);
        expect_v("mscratch_old", 32'h0);
        expect_v("mscratch_illegal", 32'h0);
        #1;
        chk(data_r); chk({31'b0, illegal});
        tick();
        read_chk("mscratch_new", 12'h340, 32'hDEAD_BEEF);

        csr(RW, 1'b0, 5'd0, 32'h0, 12'h300);
        tick();
        csr(RS, 1'b1, 5'd8, 32'h0, 12'h300);
        expect_v("csrrsi_old", 32'h0000_1800);
        #1;
        chk(data_r);
        tick();
        idle();
        expect_v("csrrsi_mie", 32'h1);
        #1;
        chk({31'b0, mie_o});
        csr(RC, 1'b0, 5'd0, 32'hFFFF_FFFF, 12'h300);
        expect_v("rc_x0_val", 32'h0000_1808);
        expect_v("rc_x0_illegal", 32'h0);
        #1;
        chk(data_r); chk({31'b0, illegal});
        tick();
        idle();
        expect_v("rc_x0_mie", 32'h1);
        #1;
        chk({31'b0, mie_o});

        csr(RS, 1'b0, 5'd5, 32'hFFFF_FFFF, 12'h304);
        tick();
        csr(RC, 1'b0, 5'd5, 32'h0000_0008, 12'h304);
        expect_v("mie_mask", 32'h0000_0888);
        #1;
        chk(data_r);
        tick();
        read_chk("mie_clear", 12'h304, 32'h0000_0880);
        csr(RW, 1'b0, 5'd1, 32'h0000_2003, 12'h305);
        tick();
        idle();
        expect_v("mtvec_align", 32'h0000_2000);
        #1;
        chk(tvec_o);
        csr(RW, 1'b0, 5'd1, 32'h0000_3007, 12'h341);
        tick();
        idle();
        expect_v("mepc_align", 32'h0000_3004);
        #1;
        chk(epc_o);

        csr(RW, 1'b0, 5'd1, 32'h0, 12'hB80);
        tick();
        csr(RW, 1'b0, 5'd1, 32'hFFFF_FFFF, 12'hB00);
        tick();
        csr(RW, 1'b0, 5'd1, 32'h0000_1234, 12'hC00);
        expect_v("ro_write_illegal", 32'h1);
        expect_v("ro_write_val", 32'hFFFF_FFFF);
        #1;
        chk({31'b0, illegal}); chk(data_r);
        tick();
        csr(RS, 1'b0, 5'd0, 32'h0, 12'hC80);
        expect_v("cycleh_carry", 32'h1);
        expect_v("ro_read_illegal", 32'h0);
        #1;
        chk(data_r); chk({31'b0, illegal});
        tick();
        read_chk("mcycle_after", 12'hB00, 32'h1);

        csr(RS, 1'b0, 5'd1, 32'h0, 12'h7C0);
        expect_v("unimpl_val", 32'h0);
        expect_v("unimpl_illegal", 32'h1);
        #1;
        chk(data_r); chk({31'b0, illegal});
        csr(NOP, 1'b0, 5'd1, 32'h0, 12'h7C0);
        expect_v("nop_illegal", 32'h0);
        #1;
        chk({31'b0, illegal});
        tick();

        csr(RW, 1'b0, 5'd1, 32'hFFFF_FFFF, 12'hB80);
        tick();
        csr(RW, 1'b0, 5'd1, 32'hFFFF_FFFF, 12'hB00);
        tick();
        idle();
        tick();
        read_chk("wrap_hi", 12'hB80, 32'h0);
        read_chk("wrap_lo", 12'hB00, 32'h1);

        csr(RW, 1'b0, 5'd1, 32'h0, 12'hB82);
        tick();
        csr(RW, 1'b0, 5'd1, 32'h0, 12'hB02);
        tick();
        idle();
        instret_inc = 1;
        repeat (5) tick();
        instret_inc = 0;
        read_chk("minstret_5", 12'hB02, 32'h5);
        read_chk("minstreth_0", 12'hB82, 32'h0);
        csr(RW, 1'b0, 5'd1, 32'd10, 12'hB02);
        instret_inc = 1;
        tick();
        instret_inc = 0;
        read_chk("minstret_wr_suppress", 12'hB02, 32'd10);

        csr(RW, 1'b0, 5'd1, 32'h1111_1111, 12'h340);
        tick();
        csr(RW, 1'b0, 5'd1, 32'h2222_2222, 12'h340);
        trap_en = 1; trap_pc = 32'h0000_1003; trap_cause = 32'hB; trap_tval = 32'h55;
        tick();
        idle();
        expect_v("trap_epc", 32'h0000_1000);
        expect_v("trap_mie", 32'h0);
        #1;
        chk(epc_o); chk({31'b0, mie_o});
        read_chk("trap_mcause", 12'h342, 32'hB);
        read_chk("trap_mtval", 12'h343, 32'h55);
        read_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        read_chk("trap_mscratch", 12'h340, 32'h1111_1111);
        idle();
        mret_en = 1;
        tick();
        idle();
        expect_v("mret_mie", 32'h1);
        #1;
        chk({31'b0, mie_o});
        read_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        csr(RW, 1'b0, 5'd1, 32'hAAAA_5555, 12'h340);
        tick();
        idle();
        instret_inc = 1;
        reset = 1;
        tick();
        reset = 0;
        instret_inc = 0;
        expect_v("rst2_epc", 32'h0);
        expect_v("rst2_tvec", TVEC_RST);
        expect_v("rst2_mie", 32'h0);
        #1;
        chk(epc_o); chk(tvec_o); chk({31'b0, mie_o});
        read_chk("rst2_mcycle", 12'hB00, 32'h0);
        read_chk("rst2_mscratch", 12'h340, 32'h0);
        read_chk("rst2_mstatus", 12'h300, 32'h0000_1800);
        read_chk("rst2_minstret", 12'hB02, 32'h0);
        read_chk("rst2_mcycleh", 12'hB80, 32'h0);
        read_chk("rst2_mcause", 12'h342, 32'h0);
        read_chk("rst2_mtvec", 12'h305, TVEC_RST);

        idle();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
